// File: rtl/score_bcd_scheduler.sv
// Round-robin shared double-dabble engine: clamps each requester's binary
// score to 9999 and latches a packed 4-digit BCD result per requester.
module score_bcd_scheduler #(
  parameter int NREQ = 2,
  parameter int W    = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] bin_in,
  output logic [NREQ-1:0]   ack,
  output logic [NREQ*16-1:0] bcd_out,
  output logic [NREQ-1:0]   valid,
  output logic [NREQ-1:0]   sat,
  output logic              busy,
  output logic              done
);

  localparam int GW = $clog2(NREQ);
  localparam int CW = $clog2(W + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_STORE = 2'd2;

  logic [1:0]         r_state;
  logic [GW-1:0]      r_last;
  logic [GW-1:0]      r_gnt;
  logic [W-1:0]       r_op;
  logic [15:0]        r_acc;
  logic [CW-1:0]      r_cnt;
  logic               r_sattmp;
  logic [NREQ-1:0]    r_ack;
  logic [NREQ*16-1:0] r_bcd;
  logic [NREQ-1:0]    r_valid;
  logic [NREQ-1:0]    r_sat;
  logic               r_done;

  logic [GW-1:0]      w_gnt;
  logic [GW-1:0]      w_idx;
  logic               w_hit;
  logic [W-1:0]       w_sel;
  logic [W-1:0]       w_opnd;
  logic               w_over;
  logic [15:0]        w_adj;

  // Walk from last_grant+1, wrapping, and take the first live request
  always_comb begin
    w_gnt = r_last;
    w_idx = r_last;
    w_hit = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (w_idx == GW'(NREQ - 1)) w_idx = '0;
      else                        w_idx = w_idx + 1'b1;
      if (!w_hit && req[w_idx]) begin
        w_hit = 1'b1;
        w_gnt = w_idx;
      end
    end
  end

  always_comb begin
    w_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt == GW'(i)) w_sel = bin_in[i*W +: W];
    end
    w_over = (32'(w_sel) > 32'd9999);
    w_opnd = w_over ? W'(32'd9999) : w_sel;
  end

  // All digits judged on pre-adjust values
  always_comb begin
    w_adj = r_acc;
    for (int d = 0; d < 4; d++) begin
      if (r_acc[d*4 +: 4] >= 4'd5) w_adj[d*4 +: 4] = r_acc[d*4 +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_last   <= GW'(NREQ - 1);
      r_gnt    <= '0;
      r_op     <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_sattmp <= 1'b0;
      r_ack    <= '0;
      r_bcd    <= '0;
      r_valid  <= '0;
      r_sat    <= '0;
      r_done   <= 1'b0;
    end else begin
      r_ack  <= '0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_hit) begin
            r_op         <= w_opnd;
            r_sattmp     <= w_over;
            r_acc        <= '0;
            r_cnt        <= '0;
            r_gnt        <= w_gnt;
            r_ack[w_gnt] <= 1'b1;
            r_state      <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_acc <= (w_adj << 1) | {15'd0, r_op[W-1]};
          r_op  <= r_op << 1;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(W - 1)) r_state <= S_STORE;
        end
        S_STORE: begin
          for (int i = 0; i < NREQ; i++) begin
            if (r_gnt == GW'(i)) begin
              r_bcd[i*16 +: 16] <= r_acc;
              r_sat[i]          <= r_sattmp;
              r_valid[i]        <= 1'b1;
            end
          end
          r_done  <= 1'b1;
          r_last  <= r_gnt;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ack     = r_ack;
  assign bcd_out = r_bcd;
  assign valid   = r_valid;
  assign sat     = r_sat;
  assign done    = r_done;
  assign busy    = (r_state != S_IDLE);

endmodule

// File: tb/tb_score_bcd_scheduler.sv
// Directed bench for score_bcd_scheduler: vector table, contention,
// operand stability, mid-conversion reset and a strided value sweep.
module tb_score_bcd_scheduler;

  localparam int NREQ = 2;
  localparam int W    = 14;

  logic              clk;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] bin_in;
  logic [NREQ-1:0]   ack;
  logic [NREQ*16-1:0] bcd_out;
  logic [NREQ-1:0]   valid;
  logic [NREQ-1:0]   sat;
  logic              busy;
  logic              done;

  int checks = 0;
  int failures = 0;

  score_bcd_scheduler #(.NREQ(NREQ), .W(W)) dut (
    .clk(clk), .reset(reset), .req(req), .bin_in(bin_in),
    .ack(ack), .bcd_out(bcd_out), .valid(valid), .sat(sat),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [13:0] v;
    logic [15:0] bcd;
    logic        sat;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] bcd_of(input int v);
    int m;
    m = (v > 9999) ? 9999 : v;
    return {4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  task automatic convert(input int id, input logic [13:0] v,
                         input logic [15:0] eb, input logic es,
                         input string nm);
    int n;
    bit got;
    bin_in[id*W +: W] = v;
    req[id] = 1'b1;
    n = 0;
    got = 0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (ack[id]) got = 1;
    end
    req[id] = 1'b0;
    chk({nm, " ack_seen"}, 32'(got), 32'd1);
    if (got) begin
      chk({nm, " ack_onehot"}, 32'(ack), 32'(1 << id));
      chk({nm, " busy_run"}, 32'(busy), 32'd1);
      n = 0;
      got = 0;
      while (!got && n < 40) begin
        @(negedge clk);
        n++;
        if (done) got = 1;
      end
      chk({nm, " latency"}, 32'(n), 32'(W + 1));
      chk({nm, " bcd"}, 32'(bcd_out[id*16 +: 16]), 32'(eb));
      chk({nm, " sat"}, 32'(sat[id]), 32'(es));
      chk({nm, " valid"}, 32'(valid[id]), 32'd1);
      @(negedge clk);
      chk({nm, " idle"}, {30'd0, busy, done}, 32'd0);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  vec_t tbl[8];
  int   order[4];
  int   tstamp[4];

  initial begin
    int t, na, n;
    bit seen;
    tbl[0] = '{0, 14'd1234,  16'h1234, 1'b0};
    tbl[1] = '{1, 14'd16383, 16'h9999, 1'b1};
    tbl[2] = '{1, 14'd9999,  16'h9999, 1'b0};
    tbl[3] = '{0, 14'd0,     16'h0000, 1'b0};
    tbl[4] = '{1, 14'd10000, 16'h9999, 1'b1};
    tbl[5] = '{0, 14'd9998,  16'h9998, 1'b0};
    tbl[6] = '{1, 14'd5,     16'h0005, 1'b0};
    tbl[7] = '{0, 14'd8191,  16'h8191, 1'b0};

    bin_in = '0;
    do_reset();
    chk("rst ack", 32'(ack), 32'd0);
    chk("rst bcd", bcd_out, 32'd0);
    chk("rst valid_sat", {28'd0, valid, sat}, 32'd0);
    chk("rst busy_done", {30'd0, busy, done}, 32'd0);

    for (int i = 0; i < 8; i++) begin
      convert(tbl[i].id, tbl[i].v, tbl[i].bcd, tbl[i].sat,
              $sformatf("vec%0d", i));
    end
    chk("vec other slice", 32'(bcd_out[31:16]), 32'h0005);

    // contention with both requests held from reset
    do_reset();
    bin_in = {14'd4321, 14'd0};
    req = 2'b11;
    t = 0;
    na = 0;
    while (na < 4 && t < 100) begin
      @(negedge clk);
      t++;
      if (ack != 2'b00) begin
        chk("cont onehot", 32'(ack == 2'b01 || ack == 2'b10), 32'd1);
        order[na] = ack[1] ? 1 : 0;
        tstamp[na] = t;
        na++;
      end
    end
    req = 2'b00;
    chk("cont count", 32'(na), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < na) chk($sformatf("cont order%0d", i), 32'(order[i]), 32'(i % 2));
      if (i > 0 && i < na)
        chk($sformatf("cont gap%0d", i), 32'(tstamp[i] - tstamp[i-1]), 32'd16);
    end
    n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("cont bcd", bcd_out, {16'h4321, 16'h0000});
    chk("cont valid", 32'(valid), 32'd3);
    chk("cont sat", 32'(sat), 32'd0);

    // operand changed after capture must not affect the result
    bin_in[13:0] = 14'd57;
    req[0] = 1'b1;
    n = 0;
    seen = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (ack[0]) seen = 1;
    end
    req[0] = 1'b0;
    chk("stab ack", 32'(seen), 32'd1);
    repeat (2) @(negedge clk);
    bin_in[13:0] = 14'd8888;
    n = 0;
    seen = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (done) seen = 1;
    end
    chk("stab done", 32'(seen), 32'd1);
    chk("stab bcd", 32'(bcd_out[15:0]), 32'h0057);

    // reset in the middle of a conversion
    @(negedge clk);
    bin_in[13:0] = 14'd5000;
    req[0] = 1'b1;
    n = 0;
    seen = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (ack[0]) seen = 1;
    end
    req[0] = 1'b0;
    chk("mid ack", 32'(seen), 32'd1);
    repeat (6) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid clr bcd", bcd_out, 32'd0);
    chk("mid clr flags", {26'd0, valid, sat, busy, done}, 32'd0);
    chk("mid clr ack", 32'(ack), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done || busy) seen = 1;
    end
    chk("mid no done", 32'(seen), 32'd0);
    convert(0, 14'd5000, 16'h5000, 1'b0, "mid after");

    // strided sweep plus clamp boundaries
    for (int v = 0; v < 16384; v += 61) begin
      convert(0, 14'(v), bcd_of(v), 1'(v > 9999), $sformatf("sweep%0d", v));
    end
    convert(0, 14'd16383, bcd_of(16383), 1'b1, "sweep16383");
    convert(0, 14'd10000, bcd_of(10000), 1'b1, "sweep10000");
    convert(0, 14'd9999,  bcd_of(9999),  1'b0, "sweep9999");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
